// File: rtl/register_file.sv
// register_file: general-purpose register bank for the processor datapath.
// Two independent combinational read ports and one synchronous write port.
// Every entry, including entry 0, is an ordinary read/write register.
// Reset is synchronous and active-high. It clears all entries and takes
// priority over a write on the same edge.
// There is no write-to-read bypass: reads always show stored contents.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    output logic [DATA_WIDTH-1:0] q1,
    output logic [DATA_WIDTH-1:0] q2,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Read-side view of every entry. Each element is driven by exactly one
    // generate instance, so the read muxes can index a single array.
    logic [DATA_WIDTH-1:0] mem_rd [DEPTH];

    // One-hot decode of the write address, qualified by the write enable.
    logic [DEPTH-1:0] write_sel;

    // Decode the write port into one select line per entry.
    always_comb begin
        write_sel = '0;
        if (we) begin
            write_sel[waddr] = 1'b1;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [DATA_WIDTH-1:0] entry_q;
        logic [DATA_WIDTH-1:0] entry_d;

        // Next value of this entry: load write data when selected, else hold.
        always_comb begin
            entry_d = entry_q;
            if (write_sel[gi]) begin
                entry_d = data;
            end
        end

        // Storage flop; reset wins over any write on the same edge.
        always_ff @(posedge clk) begin
            if (reset) begin
                entry_q <= '0;
            end else begin
                entry_q <= entry_d;
            end
        end

        assign mem_rd[gi] = entry_q;
    end

    // Both read ports are plain combinational muxes over stored contents.
    // An X address propagates to X data; no sanitising is done here.
    assign q1 = mem_rd[raddr1];
    assign q2 = mem_rd[raddr2];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file. Expected read values are
// pushed to a scoreboard queue when read addresses are driven, then popped
// and compared once the combinational outputs have settled.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;
    localparam logic [31:0] BASE = 32'd2008040112;

    logic [DW-1:0] q1, q2, data;
    logic          clk, reset, we;
    logic [AW-1:0] waddr, raddr1, raddr2;

    int tests_run;
    int tests_failed;

    typedef struct {
        string       tag;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb[$];

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .q1     (q1),
        .q2     (q2),
        .data   (data),
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .waddr  (waddr),
        .raddr1 (raddr1),
        .raddr2 (raddr2)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Pop one scoreboard entry and compare both read ports against it.
    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_empty: got 0 entries, required at least 1");
            return;
        end
        e = sb.pop_front();
        tests_run++;
        assert (q1 === e.e1) else begin
            tests_failed++;
            $error("FAIL %s q1: observed %h expected %h", e.tag, q1, e.e1);
        end
        tests_run++;
        assert (q2 === e.e2) else begin
            tests_failed++;
            $error("FAIL %s q2: observed %h expected %h", e.tag, q2, e.e2);
        end
    endtask

    // Drive both read addresses, queue the expectation, let outputs settle
    // (well away from any clock edge when called on a negedge or just after
    // a posedge), then check.
    task automatic rd(input string tag, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [31:0] e1,
                      input logic [31:0] e2);
        exp_t e;
        raddr1 = a1;
        raddr2 = a2;
        e.tag = tag;
        e.e1  = e1;
        e.e2  = e2;
        sb.push_back(e);
        #10;
        compare_out();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset  = 1'b1;
        we     = 1'b0;
        data   = '0;
        waddr  = '0;
        raddr1 = '0;
        raddr2 = '0;

        // Reset held across edges: every entry reads 0 on both ports.
        repeat (2) @(posedge clk);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            rd("reset_sweep", AW'(i), AW'(N - 1 - i), 32'd0, 32'd0);
        end

        // Fill: one write per cycle, address i gets BASE + i.
        @(negedge clk);
        reset = 1'b0;
        we    = 1'b1;
        for (int i = 0; i < N; i++) begin
            waddr = AW'(i);
            data  = BASE + 32'(i);
            @(negedge clk);
        end
        we = 1'b0;

        // Readback: port 1 at i, port 2 at its neighbour (wrapping at 31).
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            rd("fill_readback", AW'(i), AW'((i + 1) % N),
               BASE + 32'(i), BASE + 32'((i + 1) % N));
        end

        // Write enable low: entry 5 must ignore data across several edges.
        @(negedge clk);
        we    = 1'b0;
        waddr = 5'd5;
        data  = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rd("we_low_hold", 5'd5, 5'd5, BASE + 32'd5, BASE + 32'd5);

        // Same-cycle read/write on entry 7: old value before, new after.
        @(negedge clk);
        waddr = 5'd7;
        data  = 32'h12345678;
        we    = 1'b1;
        rd("rw_same_before", 5'd7, 5'd7, BASE + 32'd7, BASE + 32'd7);
        @(posedge clk);
        rd("rw_same_after", 5'd7, 5'd7, 32'h12345678, 32'h12345678);
        @(negedge clk);
        we = 1'b0;

        // Overwrite entry 31 on consecutive edges; entry 30 untouched.
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd31;
        data  = 32'hA5A5A5A5;
        @(posedge clk);
        rd("overwrite_first", 5'd31, 5'd30, 32'hA5A5A5A5, BASE + 32'd30);
        @(negedge clk);
        data = 32'h5A5A5A5A;
        @(negedge clk);
        we = 1'b0;
        rd("overwrite_second", 5'd31, 5'd30, 32'h5A5A5A5A, BASE + 32'd30);

        // Reset vs write: nothing changes before the edge, everything is 0
        // after it, including the entry being written.
        @(negedge clk);
        reset = 1'b1;
        we    = 1'b1;
        waddr = 5'd3;
        data  = 32'hFFFFFFFF;
        rd("reset_between_edges", 5'd3, 5'd0, BASE + 32'd3, BASE);
        @(posedge clk);
        rd("reset_beats_write", 5'd3, 5'd31, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        we    = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            rd("post_reset_sweep", AW'(i), AW'(N - 1 - i), 32'd0, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Parameterised multi-port register file: two independent asynchronous read ports and one synchronous write port, 32 entries × 32 bits by default. It serves as the general-purpose register bank of the processor datapath: the decode stage drives the two read addresses and writeback drives the write port. Every entry, including entry 0, is an ordinary read/write register; there is no hardwired-zero register.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data/read ports
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH (32 entries)

Ports (positional order in the codebase is q1, q2, data, clk, reset, we, waddr, raddr1, raddr2):
- clk  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high; clears every entry
- q1  output  DATA_WIDTH  read data for raddr1
- q2  output  DATA_WIDTH  read data for raddr2
- data  input  DATA_WIDTH  write data
- we  input  1  write enable, active-high
- waddr  input  ADDR_WIDTH  write address
- raddr1  input  ADDR_WIDTH  read address, port 1
- raddr2  input  ADDR_WIDTH  read address, port 2

## Operation
- Storage: array of 2**ADDR_WIDTH registers, each DATA_WIDTH bits.
- Reset: on a rising clk edge with reset=1, all entries become 0. Reset has priority over write: with reset=1 and we=1, no write takes effect.
- Write: on a rising clk edge with reset=0 and we=1, mem[waddr] <= data. With we=0, all entries hold.
- Read: q1 = mem[raddr1] and q2 = mem[raddr2], purely combinational. The two ports are fully independent and may address the same entry.
- No write-to-read bypass: the read ports reflect stored contents only.
- Every address value 0..2**ADDR_WIDTH-1 is valid; there is no out-of-range case.
- X/undriven read addresses produce X on the outputs; the block does no sanitising.

## Timing
- Write latency: 1 edge. Data presented before edge N is visible on a read port that addresses it immediately after edge N (same cycle, combinational).
- Same-cycle read/write to the same address: the port shows the old value before the edge and the new value after it.
- Read latency: 0 cycles. Output settles combinationally after a change to raddr or to the addressed entry.
- Outputs after reset: q1 = q2 = 0 for every address, from the first reset edge until a write occurs.
- Reset asserted mid-operation: the next rising edge clears all 32 entries regardless of we, waddr and data. Outputs go to 0 combinationally after that edge.
- Reset has no effect between clock edges, because it is synchronous.

## Test plan
- Reset: hold reset=1 across edges, then sweep raddr1/raddr2 over 0..31 -> q1 = q2 = 0 everywhere.
- Fill and readback: reset=0, we=1, write 2008040112 + i to address i for i = 0..31 (one per 100 ns cycle), then we=0 and read raddr1 = i, raddr2 = (i+1) mod 32 -> q1 = 2008040112 + i and q2 = 2008040112 + ((i+1) mod 32). This checks that r0 = 2008040112 is kept, not forced to 0, and that r31 = 2008040143.
- Write enable low: we=0, data = 32'hDEADBEEF, waddr = 5 for several edges -> mem[5] keeps its prior value (2008040117 after the fill).
- Same-cycle read/write: raddr1 = waddr = 7, we=1, data = 32'h12345678 -> q1 shows the old value before the edge and 32'h12345678 after it. With raddr2 = 7 as well, q2 matches q1.
- Reset vs write: after the fill, assert reset=1 with we=1, waddr = 3, data = 32'hFFFFFFFF for one edge -> all entries, including 3, read 0.
- Overwrite: write 32'hA5A5A5A5 to 31, then 32'h5A5A5A5A to 31 on the next edge -> q1 (raddr1 = 31) = 32'h5A5A5A5A, and neighbour 30 is unchanged.
